sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Switch conditioning stage directly upstream of the counter/shift-register LED path.
//  Synchronises the raw asynchronous board switches i_sw into the clock domain.
//  Debounces each bit independently.
//  Drives clean levels (o_sw) plus per-bit one-cycle rise/fall pulses and an any-change pulse.
//  The LED top consumes o_sw in place of raw switches; o_change can restart the tick counter.
// PARAMETERS
//  SW_WIDTH         4          number of switch bits conditioned
//  DEBOUNCE_CYCLES  1000000    cycles a new level must hold before commit (>=1; 10 ms @ 100 MHz)
//  RESET_VALUE      {SW_WIDTH{1'b0}}  value of o_sw and of both sync stages during reset
// PORTS
//  clock         in   1         single clock, all flops rising-edge
//  i_reset       in   1         asynchronous reset, active-low (0 = reset)
//  i_sw          in   SW_WIDTH  raw switch inputs, asynchronous to clock
//  o_sw          out  SW_WIDTH  debounced, registered switch levels
//  o_rise        out  SW_WIDTH  1-cycle pulse per bit when o_sw bit commits 0->1
//  o_fall        out  SW_WIDTH  1-cycle pulse per bit when o_sw bit commits 1->0
//  o_change      out  1         1-cycle pulse: OR of all o_rise|o_fall bits, registered with them
// BEHAVIOUR
//  - Reset (i_reset=0, async): o_sw=RESET_VALUE; sync1/sync2=RESET_VALUE; o_rise=o_fall=0; o_change=0;
//    all bit FSMs in S_STABLE; counters 0. Reset takes effect mid-count with no pulse emitted.
//  - Sync: 2-flop chain per bit, sync1<=i_sw, sync2<=sync1. Only sync2 feeds the FSM.
//  - Per-bit FSM, CNT_W=$clog2(DEBOUNCE_CYCLES) bits (min 1), two states:
//    S_STABLE: cnt=0. If sync2!=o_sw: go S_COUNT, cnt<=0.
//    S_COUNT:  if sync2==o_sw: go S_STABLE, cnt<=0, no pulse (glitch rejected).
//              elif cnt==DEBOUNCE_CYCLES-1: o_sw<=sync2, pulse rise/fall, go S_STABLE, cnt<=0.
//              else cnt<=cnt+1.
//  - Any bounce back to the old level restarts the hold window from zero. No partial credit.
//  - Latency: new stable level first sampled by sync1 at edge k; o_sw commits at edge k+2+DEBOUNCE_CYCLES.
//    Total is DEBOUNCE_CYCLES+3 edges inclusive of k.
//  - Counter saturates by construction: it never exceeds DEBOUNCE_CYCLES-1. No wrap.
//  - o_rise/o_fall are high exactly the one cycle after the commit edge. They are registered and never both high on a bit.
//  - Bits are independent. Simultaneous commits on several bits assert their pulses in the same cycle and give a single o_change pulse.
//  - A level held shorter than DEBOUNCE_CYCLES+? in sync2 never reaches o_sw.
//    Precisely: sync2 must differ from o_sw for DEBOUNCE_CYCLES+1 consecutive edges.
//  - DEBOUNCE_CYCLES=1: commit on the edge after entering S_COUNT.
// STRUCTURE
//  - Package sw_debounce_pkg: state encoding localparams S_STABLE=1'b0, S_COUNT=1'b1,
//    and a clog2-safe CNT_W function.
//  - Sub-module sw_debounce_bit, instantiated SW_WIDTH times via generate. It contains:
//    2-flop sync, FSM, counter, level and rise/fall regs.
//  - Top level holds only the generate loop and the registered o_change OR-reduction.
// TESTING  (DEBOUNCE_CYCLES=4, SW_WIDTH=4, RESET_VALUE=0)
//  1. Release reset with i_sw=4'b0000, run 20 cycles -> o_sw=0000; o_rise, o_fall, o_change never assert.
//  2. i_sw[0] 0->1 before edge k, held -> o_sw[0]=1 after edge k+6 (7 edges).
//     o_rise[0]=1 and o_change=1 for exactly that one cycle.
//  3. i_sw[1]=1 for 3 cycles then 0 -> o_sw stays 0000, zero pulses.
//  4. i_sw[2] toggles every 2 cycles for 10 cycles, then steady 1 -> exactly one o_rise[2].
//     It lands 7 edges after the final 0->1 is sampled.
//  5. i_sw[3:2] 00->11 on the same edge -> both o_sw bits commit the same cycle;
//     o_rise=4'b1100, single-cycle o_change.
//  6. i_sw[0] 0->1, assert i_reset=0 when cnt=2 -> o_sw=0 immediately, no pulse.
//     Release with i_sw[0]=1 -> commit after full 7-edge latency again.
//  Also: 1->0 variant of 2 checks o_fall. Assertion: o_rise&o_fall==0 always.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debounce block: bit FSM state encoding
// and the counter-width helper.
package sw_debounce_pkg;

  localparam logic S_STABLE = 1'b0;
  localparam logic S_COUNT  = 1'b1;

  // Counter width able to hold DEBOUNCE_CYCLES-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned cycles);
    int unsigned w;
    w = 32'd1;
    if (cycles > 32'd1) begin
      w = 32'($clog2(cycles));
    end
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, hold-window FSM with counter,
// committed level and registered rise/fall pulses.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_async,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned      CNT_W    = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1;
  logic             sync2;
  logic             state_q;
  logic             state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             differs;
  logic             window_done;

  // Only sync2 is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_async;
      sync2 <= sync1;
    end
  end

  assign differs     = (sync2 != level);
  assign window_done = (cnt_q == CNT_LAST);

  // State register, plus counter, level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_STABLE;
      cnt_q   <= '0;
      level   <= RESET_VALUE;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_c;
      fall    <= fall_c;
    end
  end

  // Next state: any return to the committed level aborts the window.
  always_comb begin
    state_d = state_q;
    if (state_q == S_STABLE) begin
      if (differs) begin
        state_d = S_COUNT;
      end
    end else begin
      if (!differs || window_done) begin
        state_d = S_STABLE;
      end
    end
  end

  // Counter advance and commit; the counter stops at CNT_LAST by construction.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    if (state_q == S_COUNT && differs) begin
      if (window_done) begin
        level_d = sync2;
        rise_c  = sync2;
        fall_c  = ~sync2;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning: per-bit synchronise and debounce, plus a registered
// any-change pulse aligned with the per-bit rise/fall pulses.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned         SW_WIDTH        = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = 1000000,
  parameter logic [SW_WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [SW_WIDTH-1:0] i_sw,
  output logic [SW_WIDTH-1:0] o_sw,
  output logic [SW_WIDTH-1:0] o_rise,
  output logic [SW_WIDTH-1:0] o_fall,
  output logic                o_change
);

  logic [SW_WIDTH-1:0] rise_c;
  logic [SW_WIDTH-1:0] fall_c;

  for (genvar i = 0; i < int'(SW_WIDTH); i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_bit (
      .clk      (clock),
      .rst_n    (i_reset),
      .sw_async (i_sw[i]),
      .level    (o_sw[i]),
      .rise     (o_rise[i]),
      .fall     (o_fall[i]),
      .rise_c   (rise_c[i]),
      .fall_c   (fall_c[i])
    );
  end

  // Built from the pre-register strobes so it lands in the same cycle as o_rise/o_fall.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_change <= 1'b0;
    end else begin
      o_change <= |(rise_c | fall_c);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a four-cycle hold window on four bits.
module tb_sw_debounce;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;
  localparam int unsigned LAT = D + 2;

  logic         clock;
  logic         i_reset;
  logic [W-1:0] i_sw;
  logic [W-1:0] o_sw;
  logic [W-1:0] o_rise;
  logic [W-1:0] o_fall;
  logic         o_change;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    logic         exp_ch;
  } vec_t;

  vec_t vecs[$];

  sw_debounce #(
    .SW_WIDTH        (W),
    .DEBOUNCE_CYCLES (D),
    .RESET_VALUE     ('0)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_sw     (i_sw),
    .o_sw     (o_sw),
    .o_rise   (o_rise),
    .o_fall   (o_fall),
    .o_change (o_change)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if ((o_rise & o_fall) != '0) overlap++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold sw for n cycles starting from committed level old; commit lands LAT records in.
  function automatic void hold(input logic [W-1:0] sw, input logic [W-1:0] old, input int n);
    vec_t v;
    for (int j = 0; j < n; j++) begin
      v.sw       = sw;
      v.exp_sw   = (j >= int'(LAT)) ? sw : old;
      v.exp_rise = (j == int'(LAT)) ? (sw & ~old) : '0;
      v.exp_fall = (j == int'(LAT)) ? (old & ~sw) : '0;
      v.exp_ch   = (j == int'(LAT)) && (sw != old);
      vecs.push_back(v);
    end
  endfunction

  logic [W-1:0] sw2;
  logic         seen;

  initial begin
    i_reset = 1'b0;
    i_sw    = '0;
    repeat (3) @(negedge clock);
    chk("reset_state", 32'({o_sw, o_rise, o_fall, o_change}), 32'd0);
    i_reset = 1'b1;

    // Idle after reset: nothing moves.
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if ((o_rise | o_fall) != '0 || o_change) seen = 1'b1;
    end
    chk("idle_sw", 32'(o_sw), 32'd0);
    chk("idle_no_pulse", 32'(seen), 32'd0);

    // Rise and fall on bit 0, short pulse on bit 1, joint commit on bits 3:2.
    hold(4'b0001, 4'b0000, 9);
    hold(4'b0000, 4'b0001, 9);
    hold(4'b0010, 4'b0000, 3);
    hold(4'b0000, 4'b0000, 8);
    hold(4'b1100, 4'b0000, 8);
    hold(4'b0000, 4'b1100, 8);
    for (int i = 0; i < vecs.size(); i++) begin
      i_sw = vecs[i].sw;
      @(negedge clock);
      chk($sformatf("vec%0d", i), 32'({o_sw, o_rise, o_fall, o_change}),
          32'({vecs[i].exp_sw, vecs[i].exp_rise, vecs[i].exp_fall, vecs[i].exp_ch}));
    end

    // Bouncing bit 2: only the final steady high commits, LAT records after it starts.
    for (int c = 0; c < 20; c++) begin
      sw2 = '0;
      sw2[2] = (c >= 10) ? 1'b1 : ((c % 4) < 2);
      i_sw = sw2;
      @(negedge clock);
      if (c == 8 + int'(LAT) || c == 7 || c == 10 || c == 19) begin
        chk($sformatf("bounce_c%0d", c), 32'({o_sw, o_rise, o_fall, o_change}),
            (c >= 8 + int'(LAT)) ? 32'({4'b0100, (c == 8 + int'(LAT)) ? 4'b0100 : 4'b0000,
                                        4'b0000, c == 8 + int'(LAT)}) : 32'd0);
      end else if ((o_rise | o_fall) != '0) begin
        chk($sformatf("bounce_extra_c%0d", c), 32'({o_rise, o_fall}), 32'd0);
      end
    end
    i_sw = '0;
    repeat (10) @(negedge clock);
    chk("bounce_release", 32'(o_sw), 32'd0);

    // Reset mid-count, then a full-latency commit after release.
    i_sw = 4'b0001;
    repeat (5) @(negedge clock);
    chk("pre_reset_sw", 32'(o_sw), 32'd0);
    i_reset = 1'b0;
    #1;
    chk("mid_reset", 32'({o_sw, o_rise, o_fall, o_change}), 32'd0);
    repeat (2) @(negedge clock);
    i_reset = 1'b1;
    for (int c = 0; c <= int'(LAT) + 1; c++) begin
      @(negedge clock);
      chk($sformatf("post_reset_c%0d", c), 32'({o_sw, o_rise, o_change}),
          32'({(c >= int'(LAT)) ? 4'b0001 : 4'b0000,
               (c == int'(LAT)) ? 4'b0001 : 4'b0000, c == int'(LAT)}));
    end

    chk("rise_fall_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
